// File: rtl/riscv_core_pkg.sv
// Shared fetch-stage types: next-PC selects, fetch FSM states, fault codes.
// Also holds decode-field helpers used downstream of pc_fetch_unit.
package riscv_core_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    PC_NA     = 2'b00,
    PC_NORMAL = 2'b01,
    PC_JUMP   = 2'b10,
    PC_BRANCH = 2'b11
  } pc_ctrl_e;

  typedef enum logic [1:0] {
    RST,
    FETCH,
    EXEC,
    HALT
  } fetch_state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_PC_NA    = 2'b01,
    FLT_TIMEOUT  = 2'b10,
    FLT_MISALIGN = 2'b11
  } fault_e;

  function automatic logic [4:0] op_code(
    input logic [INSTR_W-1:0] ins
  );
    return ins[6:2];
  endfunction

  function automatic logic [3:0] sub_op_code(
    input logic [INSTR_W-1:0] ins
  );
    return {ins[30], ins[14:12]};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/valid handshake between fetch and imem.
// master = fetch unit, slave = memory.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  import riscv_core_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC mux, link adder and alignment handling.
// MISALIGN_TRAP_EN: misaligned candidate raises trap instead of being masked.
module pc_next_calc
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  pc_ctrl_e        pc_control,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap
);

  logic [XLEN-1:0] cand;
  logic [XLEN-1:0] raw;

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    cand = pc_plus4;
    raw  = pc_plus4;
    unique case (1'b1)
      (pc_control == PC_JUMP): begin
        cand = {jump_target[XLEN-1:1], 1'b0};
        raw  = jump_target;
      end
      (pc_control == PC_BRANCH): begin
        cand = branch_taken ? pc + branch_offset
                            : pc_plus4;
        raw  = cand;
      end
      default: begin
        cand = pc_plus4;
        raw  = pc_plus4;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Raw jump target is checked so a set bit0 still traps.
  assign pc_next = cand;
  assign trap    = (raw[1:0] != 2'b00);
`else
  logic unused_raw;
  assign unused_raw = ^raw;
  assign pc_next    = {cand[XLEN-1:2], 2'b00};
  assign trap       = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, imem handshake, instruction hold for decode.
// Optional MISALIGN_TRAP_EN turns misaligned next-PCs into fault 11.
module pc_fetch_unit
  import riscv_core_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_fetch_unit_if.master    imem,
  input  logic               stall,
  input  logic [1:0]         pc_control,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_offset,
  input  logic [XLEN-1:0]    jump_target,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  output logic               halted,
  output logic [1:0]         fault_code
);

  localparam logic [15:0] TMO = 16'(FETCH_TIMEOUT);

  fetch_state_e       state, state_n;
  logic [XLEN-1:0]    pc_n, pc_calc;
  logic [INSTR_W-1:0] instr_n;
  logic [15:0]        cnt, cnt_n;
  logic               halted_n, trap;
  logic [1:0]         fault_n;
  pc_ctrl_e           ctrl;

  assign ctrl = pc_ctrl_e'(pc_control);

  pc_next_calc #(.XLEN(XLEN)) u_next (
    .pc            (pc),
    .pc_control    (ctrl),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .pc_next       (pc_calc),
    .pc_plus4      (pc_plus4),
    .trap          (trap)
  );

  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST;
      pc         <= XLEN'(RESET_PC);
      instr      <= '0;
      cnt        <= '0;
      halted     <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      instr      <= instr_n;
      cnt        <= cnt_n;
      halted     <= halted_n;
      fault_code <= fault_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = instr;
    cnt_n    = cnt;
    halted_n = halted;
    fault_n  = fault_code;
    unique case (state)
      RST: state_n = FETCH;
      FETCH: begin
        cnt_n = cnt + 16'd1;
        if (imem.imem_valid) begin
          instr_n = imem.imem_rdata;
          cnt_n   = '0;
          state_n = EXEC;
        end else if (TMO != 16'd0 && cnt_n == TMO) begin
          state_n  = HALT;
          halted_n = 1'b1;
          fault_n  = FLT_TIMEOUT;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (ctrl == PC_NA) begin
            state_n  = HALT;
            halted_n = 1'b1;
            fault_n  = FLT_PC_NA;
          end else if (trap) begin
            state_n  = HALT;
            halted_n = 1'b1;
            fault_n  = FLT_MISALIGN;
          end else begin
            pc_n    = pc_calc;
            state_n = FETCH;
          end
        end
      end
      HALT: halted_n = 1'b1;
      default: state_n = RST;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (FETCH_TIMEOUT=4).
// Memory model answers every request in the same cycle when enabled.
module tb_pc_fetch_unit;
  import riscv_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b1;
  logic [1:0]  pc_control = 2'b01;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, halted;
  logic [1:0]  fault_code;
  logic        mem_en = 1'b1;
  logic [31:0] rdata_v = 32'h0000_0013;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.XLEN(32)) imem ();
  assign imem.imem_valid = mem_en & imem.imem_req;
  assign imem.imem_rdata = rdata_v;

  pc_fetch_unit #(
    .XLEN          (32),
    .RESET_PC      (32'h0000_0000),
    .FETCH_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem),
    .stall         (stall),
    .pc_control    (pc_control),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .halted        (halted),
    .fault_code    (fault_code)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // From EXEC: release one instruction with the given select.
  task automatic go(input logic [1:0]  ctl,
                    input logic        tk,
                    input logic [31:0] off,
                    input logic [31:0] jt);
    pc_control    = ctl;
    branch_taken  = tk;
    branch_offset = off;
    jump_target   = jt;
    stall         = 1'b0;
    step();
    stall         = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem.imem_req), 32'h0);
    chk("rst_ivalid", 32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_fault", 32'(fault_code), 32'h0);
    chk("rst_instr", instr, 32'h0);

    rst_n = 1'b1;
    step();
    chk("t1_req", 32'(imem.imem_req), 32'h1);
    chk("t1_addr0", imem.imem_addr, 32'h0);
    step();
    chk("t1_ivalid", 32'(instr_valid), 32'h1);
    chk("t1_instr", instr, 32'h0000_0013);
    chk("t1_pc", pc, 32'h0);
    chk("t1_pc4", pc_plus4, 32'h4);
    go(2'b01, 1'b0, 32'h0, 32'h0);
    chk("t1_addr4", imem.imem_addr, 32'h4);
    step();

    go(2'b10, 1'b0, 32'h0, 32'h100);
    chk("t2_jmp", pc, 32'h100);
    step();
    go(2'b11, 1'b1, 32'hFFFF_FFF8, 32'h0);
    chk("t2_taken", pc, 32'h0F8);
    step();
    go(2'b10, 1'b0, 32'h0, 32'h100);
    step();
    go(2'b11, 1'b0, 32'hFFFF_FFF8, 32'h0);
    chk("t2_ntaken", pc, 32'h104);
    step();

    go(2'b10, 1'b0, 32'h0, 32'h2001);
`ifdef MISALIGN_TRAP_EN
    chk("t3_halt", 32'(halted), 32'h1);
    chk("t3_fault", 32'(fault_code), 32'h3);
    chk("t3_pc", pc, 32'h104);
    do_reset();
    step();
    go(2'b10, 1'b0, 32'h0, 32'h2000);
`else
    chk("t3_pc", pc, 32'h2000);
    chk("t3_nohalt", 32'(halted), 32'h0);
`endif
    rdata_v = 32'h4000_50B3;
    step();
    chk("t4_instr", instr, 32'h4000_50B3);
    rdata_v = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_pc", pc, 32'h2000);
      chk("t4_instr_hold", instr, 32'h4000_50B3);
      chk("t4_req", 32'(imem.imem_req), 32'h0);
    end
    go(2'b01, 1'b0, 32'h0, 32'h0);
    chk("t4_rel", pc, 32'h2004);
    step();

    go(2'b10, 1'b0, 32'h0, 32'hFFFF_FFFC);
    step();
    chk("t6_pc4wrap", pc_plus4, 32'h0);
    go(2'b01, 1'b0, 32'h0, 32'h0);
    chk("t6_wrap", pc, 32'h0);
    chk("t6_nofault", 32'(halted), 32'h0);
    step();
    go(2'b00, 1'b0, 32'h0, 32'h0);
    chk("t6_halt", 32'(halted), 32'h1);
    chk("t6_fault", 32'(fault_code), 32'h1);
    chk("t6_pc", pc, 32'h0);
    step();
    step();
    chk("t6_sticky", 32'(halted), 32'h1);
    chk("t6_req", 32'(imem.imem_req), 32'h0);
    chk("t6_ivalid", 32'(instr_valid), 32'h0);

    mem_en = 1'b0;
    do_reset();
    chk("t5_req", 32'(imem.imem_req), 32'h1);
    step();
    step();
    step();
    chk("t5_not_yet", 32'(halted), 32'h0);
    step();
    chk("t5_halt", 32'(halted), 32'h1);
    chk("t5_fault", 32'(fault_code), 32'h2);

    mem_en = 1'b1;
    do_reset();
    step();
    mem_en = 1'b0;
    go(2'b10, 1'b0, 32'h0, 32'h40);
    chk("t5_addr", imem.imem_addr, 32'h40);
    chk("t5_req2", 32'(imem.imem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(imem.imem_req), 32'h0);
    chk("t5_rst_pc", pc, 32'h0);
    chk("t5_rst_flt", 32'(fault_code), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
